skeleton_driver: RTL and testbench

Host-side driver for the FPGA test skeletons: it is the block that feeds a skeleton instead of answering. It accepts a command byte stream, assembles one BITWIDTH_SYS-bit word, pulses the skeleton's start-calc trigger and waits for the skeleton's valid flag. It then returns the result, or the skeleton header, as a byte stream. It sits between the UART byte layer and any skeleton (echo skeleton first) on the Arty7 test design.

---
 rtl/skeleton_driver_pkg.sv | 25 ++
 rtl/skeleton_driver_if.sv | 35 +++
 rtl/skeleton_tx_serializer.sv | 44 ++++
 rtl/skeleton_driver.sv | 169 ++++++++++++++++
 tb/tb_skeleton_driver.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/skeleton_driver_pkg.sv
// Shared constants, state encoding and width helper for the skeleton driver.
package skeleton_driver_pkg;

    // Command bytes received from the host.
    localparam logic [7:0] CMD_RUN  = 8'h01;
    localparam logic [7:0] CMD_HEAD = 8'h02;

    // Single-byte error responses.
    localparam logic [7:0] RSP_TIMEOUT = 8'hEE;
    localparam logic [7:0] RSP_NAK     = 8'hEF;

    typedef enum logic [2:0] {
        IDLE,
        RX_PAY,
        TRIG,
        WAIT,
        TX
    } state_t;

    // Number of bytes needed to carry a w-bit field.
    function automatic int byte_count(input int w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/skeleton_driver_if.sv
// Byte-stream and skeleton bus bundle; master is the driver, slave the host/skeleton side.
interface skeleton_driver_if #(
    parameter int BITWIDTH_SYS  = 16,
    parameter int BITWIDTH_HEAD = 26
);
    logic [7:0]               rx_data;
    logic                     rx_valid;
    logic                     rx_ready;
    logic [7:0]               tx_data;
    logic                     tx_valid;
    logic                     tx_ready;
    logic [BITWIDTH_SYS-1:0]  skl_data_in;
    logic                     skl_trgg_start_calc;
    logic [BITWIDTH_SYS-1:0]  skl_data_out;
    logic [BITWIDTH_HEAD-1:0] skl_data_head;
    logic                     skl_data_valid;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready,
        output tx_data, tx_valid,
        input  tx_ready,
        output skl_data_in, skl_trgg_start_calc,
        input  skl_data_out, skl_data_head, skl_data_valid
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready,
        input  tx_data, tx_valid,
        output tx_ready,
        input  skl_data_in, skl_trgg_start_calc,
        output skl_data_out, skl_data_head, skl_data_valid
    );
endinterface

// File: rtl/skeleton_tx_serializer.sv
// Parallel-load byte serializer: emits a left-justified frame MSB byte first over valid/ready.
module skeleton_tx_serializer #(
    parameter int MAX_BYTES = 5,
    parameter int LEN_W     = 3
) (
    input  logic                   clk_sys,
    input  logic                   rst,
    input  logic                   load,
    input  logic [MAX_BYTES*8-1:0] frame,
    input  logic [LEN_W-1:0]       len,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   done
);
    logic [MAX_BYTES*8-1:0] shreg;
    logic [LEN_W-1:0]       remaining;
    logic                   fire;

    assign fire    = tx_valid & tx_ready;
    assign tx_data = shreg[MAX_BYTES*8-1 -: 8];
    // Flags the handshake of the final byte so the FSM can leave TX on the same edge.
    assign done    = fire && (remaining == LEN_W'(1));

    // Load a new frame, or shift out one byte per accepted transfer.
    always_ff @(posedge clk_sys) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            shreg     <= '0;
            remaining <= '0;
            tx_valid  <= 1'b0;
        end else if (load) begin
            shreg     <= frame;
            remaining <= len;
            tx_valid  <= 1'b1;
        end else if (fire) begin
            shreg     <= shreg << 8;
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
                tx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/skeleton_driver.sv
// Host-side skeleton driver: byte commands in, one start pulse per RUN, byte responses out.
module skeleton_driver
    import skeleton_driver_pkg::*;
#(
    parameter int BITWIDTH_SYS   = 16,
    parameter int BITWIDTH_HEAD  = 26,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk_sys,
    input  logic                rst,
    input  logic                en,
    skeleton_driver_if.master   bus,
    output logic                busy,
    output logic                err_timeout
);
    localparam int NB        = byte_count(BITWIDTH_SYS);
    localparam int NH        = byte_count(BITWIDTH_HEAD);
    localparam int MAX_BYTES = 1 + ((NB > NH) ? NB : NH);
    localparam int FRAME_W   = MAX_BYTES * 8;
    localparam int LEN_W     = $clog2(MAX_BYTES + 1);
    localparam int PAY_W     = NB * 8;
    localparam int HEAD_W    = NH * 8;
    localparam int TMO_W     = $clog2(TIMEOUT_CYCLES);

    state_t                  state;
    logic [2:0]              pay_cnt;
    logic [PAY_W-1:0]        pay_shreg;
    logic [PAY_W+7:0]        pay_cat;
    logic [PAY_W-1:0]        pay_next;
    logic [TMO_W-1:0]        tmo_cnt;
    logic [BITWIDTH_SYS-1:0] skl_word;
    logic                    trig;
    logic                    sync_rst;
    logic                    rx_fire;
    logic [PAY_W-1:0]        out_ext;
    logic [HEAD_W-1:0]       head_ext;
    logic                    ser_load;
    logic [FRAME_W-1:0]      ser_frame;
    logic [LEN_W-1:0]        ser_len;
    logic                    ser_done;

    // Dropping EN behaves exactly like reset.
    assign sync_rst = rst | ~en;

    // Ready is decoded from state and gated by reset so it is 0 throughout reset and
    // already 1 in the first IDLE cycle after release.
    assign bus.rx_ready = ~sync_rst & ((state == IDLE) || (state == RX_PAY));
    assign rx_fire      = bus.rx_valid & bus.rx_ready;

    assign pay_cat  = {pay_shreg, bus.rx_data};
    assign pay_next = pay_cat[PAY_W-1:0];
    assign out_ext  = PAY_W'(bus.skl_data_out);
    assign head_ext = HEAD_W'(bus.skl_data_head);

    assign bus.skl_data_in         = skl_word;
    assign bus.skl_trgg_start_calc = trig;

    // Build the response frame on the edge that decides it, so TX_VALID rises one cycle later.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        ser_load  = 1'b0;
        ser_frame = '0;
        ser_len   = LEN_W'(1);
        case (state)
            IDLE: begin
                if (rx_fire && (bus.rx_data != CMD_RUN)) begin
                    ser_load = 1'b1;
                    if (bus.rx_data == CMD_HEAD) begin
                        ser_frame[FRAME_W-1 -: 8]      = CMD_HEAD;
                        ser_frame[FRAME_W-9 -: HEAD_W] = head_ext;
                        ser_len                        = LEN_W'(1 + NH);
                    end else begin
                        ser_frame[FRAME_W-1 -: 8] = RSP_NAK;
                    end
                end
            end
            WAIT: begin
                if (bus.skl_data_valid) begin
                    ser_load                      = 1'b1;
                    ser_frame[FRAME_W-1 -: 8]     = CMD_RUN;
                    ser_frame[FRAME_W-9 -: PAY_W] = out_ext;
                    ser_len                       = LEN_W'(1 + NB);
                end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    ser_load                  = 1'b1;
                    ser_frame[FRAME_W-1 -: 8] = RSP_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    // Command FSM with registered trigger, busy, error flag and skeleton data word.
    always_ff @(posedge clk_sys) begin
        if (sync_rst) begin
            state       <= IDLE;
            pay_cnt     <= '0;
            pay_shreg   <= '0;
            tmo_cnt     <= '0;
            skl_word    <= '0;
            trig        <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            trig <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_fire) begin
                        busy <= 1'b1;
                        if (bus.rx_data == CMD_RUN) begin
                            state       <= RX_PAY;
                            pay_cnt     <= '0;
                            err_timeout <= 1'b0;
                        end else begin
                            state <= TX;
                        end
                    end
                end
                RX_PAY: begin
                    if (rx_fire) begin
                        pay_shreg <= pay_next;
                        pay_cnt   <= pay_cnt + 3'd1;
                        if (pay_cnt == 3'(NB - 1)) begin
                            skl_word <= pay_next[BITWIDTH_SYS-1:0];
                            trig     <= 1'b1;
                            state    <= TRIG;
                        end
                    end
                end
                TRIG: begin
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    // The skeleton's valid is sticky from earlier runs; only WAIT looks at it.
                    if (ser_load) begin
                        state <= TX;
                        if (!bus.skl_data_valid) begin
                            err_timeout <= 1'b1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                TX: begin
                    if (ser_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    skeleton_tx_serializer #(
        .MAX_BYTES (MAX_BYTES),
        .LEN_W     (LEN_W)
    ) u_tx_serializer (
        .clk_sys  (clk_sys),
        .rst      (sync_rst),
        .load     (ser_load),
        .frame    (ser_frame),
        .len      (ser_len),
        .tx_data  (bus.tx_data),
        .tx_valid (bus.tx_valid),
        .tx_ready (bus.tx_ready),
        .done     (ser_done)
    );
endmodule

// File: tb/tb_skeleton_driver.sv
// Self-checking bench: echo skeleton model plus a frame-level reference of expected responses.
module tb_skeleton_driver;
    localparam int BITWIDTH_SYS   = 16;
    localparam int BITWIDTH_HEAD  = 26;
    localparam int TIMEOUT_CYCLES = 8;
    localparam int NB             = (BITWIDTH_SYS + 7) / 8;
    localparam int NH             = (BITWIDTH_HEAD + 7) / 8;

    logic clk_sys = 1'b0;
    logic rst;
    logic en;
    logic busy;
    logic err_timeout;

    skeleton_driver_if #(.BITWIDTH_SYS(BITWIDTH_SYS), .BITWIDTH_HEAD(BITWIDTH_HEAD)) bus ();

    skeleton_driver #(
        .BITWIDTH_SYS   (BITWIDTH_SYS),
        .BITWIDTH_HEAD  (BITWIDTH_HEAD),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .en          (en),
        .bus         (bus),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk_sys = ~clk_sys;

    int tests = 0;
    int fails = 0;
    int trig_total = 0;
    int trig_wide = 0;
    logic trig_prev = 1'b0;
    bit echo_en = 1'b1;
    int echo_delay = 0;
    int echo_cnt = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    // Echo skeleton: returns DATA_IN after echo_delay cycles, valid stays high until the next start.
    always @(posedge clk_sys) begin
        if (rst || !echo_en) begin
            bus.skl_data_valid <= 1'b0;
            bus.skl_data_out   <= '0;
            echo_cnt           <= 0;
        end else if (bus.skl_trgg_start_calc) begin
            if (echo_delay == 0) begin
                bus.skl_data_valid <= 1'b1;
                bus.skl_data_out   <= bus.skl_data_in;
            end else begin
                bus.skl_data_valid <= 1'b0;
                echo_cnt           <= echo_delay;
            end
        end else if (echo_cnt != 0) begin
            echo_cnt <= echo_cnt - 1;
            if (echo_cnt == 1) begin
                bus.skl_data_valid <= 1'b1;
                bus.skl_data_out   <= bus.skl_data_in;
            end
        end
    end

    // Count start pulses and any pulse lasting more than one cycle.
    always @(negedge clk_sys) begin
        trig_prev <= bus.skl_trgg_start_calc;
        if (bus.skl_trgg_start_calc) begin
            trig_total <= trig_total + 1;
            if (trig_prev) trig_wide <= trig_wide + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference: the byte frame the driver must answer with for a given command.
    task automatic model_response(input logic [7:0] cmd, input logic [31:0] word,
                                  input logic [31:0] head, input bit timed_out);
        logic [63:0] w;
        logic [63:0] h;
        exp_q.delete();
        w = 64'(word) & ((64'd1 << BITWIDTH_SYS) - 64'd1);
        h = 64'(head) & ((64'd1 << BITWIDTH_HEAD) - 64'd1);
        if (cmd == 8'h01) begin
            if (timed_out) begin
                exp_q.push_back(8'hEE);
            end else begin
                exp_q.push_back(8'h01);
                for (int i = NB - 1; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
            end
        end else if (cmd == 8'h02) begin
            exp_q.push_back(8'h02);
            for (int i = NH - 1; i >= 0; i--) exp_q.push_back(h[8*i +: 8]);
        end else begin
            exp_q.push_back(8'hEF);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        @(negedge clk_sys);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && waited < 200) begin
            @(negedge clk_sys);
            waited++;
        end
        if (!bus.rx_ready) begin
            check("rx_accept_timeout", 64'd0, 64'd1);
            bus.rx_valid = 1'b0;
        end else begin
            @(posedge clk_sys);
            #1 bus.rx_valid = 1'b0;
        end
    endtask

    // Receive n bytes; with stall set, TX_READY is randomly withheld and held data is checked.
    task automatic collect(input int n, input bit stall);
        int waited;
        bit prev_stalled;
        logic [7:0] prev_data;
        got.delete();
        waited = 0;
        prev_stalled = 1'b0;
        prev_data = 8'h00;
        while (got.size() < n && waited < 200) begin
            @(negedge clk_sys);
            if (prev_stalled) check("tx_hold", {bus.tx_valid, bus.tx_data}, {1'b1, prev_data});
            bus.tx_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
            prev_stalled = bus.tx_valid && !bus.tx_ready;
            prev_data = bus.tx_data;
            waited++;
        end
        if (got.size() < n) begin
            check("tx_frame_timeout", 64'(got.size()), 64'(n));
        end else begin
            @(posedge clk_sys);
            #1;
        end
        bus.tx_ready = 1'b0;
    endtask

    task automatic compare_frame(input string tag);
        check({tag, "_len"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i), (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
        end
        @(negedge clk_sys);
        check({tag, "_idle"}, {bus.tx_valid, busy}, 2'b00);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int kind;
        int runs_done;
        bit stall;
        logic [31:0] word;
        logic [31:0] head;
        logic [7:0] nb;

        runs_done = 0;
        rst = 1'b1;
        en = 1'b1;
        bus.rx_data = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        bus.skl_data_head = 26'h0411410;

        // Reset values.
        repeat (3) @(negedge clk_sys);
        check("rst_outputs", {bus.rx_ready, bus.tx_valid, bus.tx_data, bus.skl_data_in,
                              bus.skl_trgg_start_calc, busy, err_timeout}, '0);
        rst = 1'b0;
        @(negedge clk_sys);
        check("rdy_after_rst", {bus.rx_ready, busy}, 2'b10);

        // RUN round trip with exact latency.
        echo_delay = 0;
        t0 = trig_total;
        send_byte(8'h01);
        send_byte(8'hAB);
        send_byte(8'hCD);
        runs_done++;
        check("run_skl_data_in", bus.skl_data_in, 16'hABCD);
        @(negedge clk_sys);
        check("run_trig_n1", bus.skl_trgg_start_calc, 1'b1);
        @(negedge clk_sys);
        check("run_n2", {bus.skl_trgg_start_calc, bus.tx_valid}, 2'b00);
        @(negedge clk_sys);
        check("run_n3", {bus.tx_valid, bus.tx_data}, {1'b1, 8'h01});
        collect(1 + NB, 1'b0);
        model_response(8'h01, 32'hABCD, 32'h0, 1'b0);
        compare_frame("run");
        check("run_trig_count", 64'(trig_total - t0), 64'd1);

        // HEAD: header sampled when the command byte is accepted.
        send_byte(8'h02);
        bus.skl_data_head = 26'h3FFFFFF;
        collect(1 + NH, 1'b0);
        model_response(8'h02, 32'h0, 32'h0411410, 1'b0);
        compare_frame("head");

        // Timeout: no skeleton response.
        echo_en = 1'b0;
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        runs_done++;
        repeat (TIMEOUT_CYCLES + 1) @(negedge clk_sys);
        check("tmo_early", {bus.tx_valid, err_timeout}, 2'b00);
        @(negedge clk_sys);
        check("tmo_fire", {bus.tx_valid, err_timeout, bus.tx_data}, {2'b11, 8'hEE});
        collect(1, 1'b0);
        model_response(8'h01, 32'h1234, 32'h0, 1'b1);
        compare_frame("tmo");
        check("tmo_sticky", err_timeout, 1'b1);

        // Next RUN clears the error flag on its command byte.
        echo_en = 1'b1;
        echo_delay = 2;
        send_byte(8'h01);
        check("tmo_clear", err_timeout, 1'b0);
        send_byte(8'h5A);
        send_byte(8'hC3);
        runs_done++;
        collect(1 + NB, 1'b0);
        model_response(8'h01, 32'h5AC3, 32'h0, 1'b0);
        compare_frame("run2");

        // NAK held under backpressure.
        send_byte(8'h7F);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_sys);
            check("nak_hold", {bus.tx_valid, bus.tx_data}, {1'b1, 8'hEF});
        end
        collect(1, 1'b0);
        model_response(8'h7F, 32'h0, 32'h0, 1'b0);
        compare_frame("nak");

        // Reset in the middle of a RUN payload.
        t0 = trig_total;
        send_byte(8'h01);
        send_byte(8'hAB);
        @(negedge clk_sys);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk_sys);
            check("midrst_outputs", {bus.rx_ready, bus.tx_valid, bus.tx_data, bus.skl_data_in,
                                     bus.skl_trgg_start_calc, busy, err_timeout}, '0);
        end
        rst = 1'b0;
        head = $urandom;
        bus.skl_data_head = head[BITWIDTH_HEAD-1:0];
        send_byte(8'h02);
        collect(1 + NH, 1'b0);
        model_response(8'h02, 32'h0, head, 1'b0);
        compare_frame("midrst_head");
        check("midrst_no_trig", 64'(trig_total - t0), 64'd0);

        // EN low drops the frame like reset.
        send_byte(8'h01);
        @(negedge clk_sys);
        en = 1'b0;
        @(negedge clk_sys);
        check("en_low", {bus.rx_ready, busy}, 2'b00);
        en = 1'b1;
        send_byte(8'h33);
        collect(1, 1'b0);
        model_response(8'h33, 32'h0, 32'h0, 1'b0);
        compare_frame("en_nak");

        // Randomized mix of commands, echo delays and TX backpressure.
        for (int it = 0; it < 24; it++) begin
            kind = $urandom_range(0, 2);
            stall = 1'($urandom_range(0, 1));
            if (kind == 0) begin
                word = $urandom;
                echo_delay = $urandom_range(0, 4);
                send_byte(8'h01);
                for (int i = NB - 1; i >= 0; i--) send_byte(word[8*i +: 8]);
                runs_done++;
                check("rnd_skl_in", bus.skl_data_in, word[BITWIDTH_SYS-1:0]);
                collect(1 + NB, stall);
                model_response(8'h01, word, 32'h0, 1'b0);
            end else if (kind == 1) begin
                head = $urandom;
                bus.skl_data_head = head[BITWIDTH_HEAD-1:0];
                send_byte(8'h02);
                bus.skl_data_head = ~bus.skl_data_head;
                collect(1 + NH, stall);
                model_response(8'h02, 32'h0, head, 1'b0);
            end else begin
                do nb = 8'($urandom); while (nb == 8'h01 || nb == 8'h02);
                send_byte(nb);
                collect(1, stall);
                model_response(nb, 32'h0, 32'h0, 1'b0);
            end
            compare_frame("rnd");
        end

        @(negedge clk_sys);
        check("trig_width", 64'(trig_wide), 64'd0);
        check("trig_total", 64'(trig_total), 64'(runs_done));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
